// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Control word bit order: pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush, drop.
package pipeline_hazard_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      CTRL_RUN,
      CTRL_DMEM_WAIT,
      CTRL_DROP
   } ctrl_state_t;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
      logic bubble;
      logic flush;
      logic drop;
   } ctrl_out_t;

   localparam ctrl_out_t OUT_FREEZE = 8'b00000_000;
   localparam ctrl_out_t OUT_ALL    = 8'b11111_000;
   localparam ctrl_out_t OUT_REDIR  = 8'b11111_110;
   localparam ctrl_out_t OUT_HOLD   = 8'b00111_100;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// The datapath is master, the controller is slave.
interface pipeline_hazard_ctrl_if;
   import pipeline_hazard_ctrl_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs1_s;
   logic [REG_W-1:0] id_rs2_s;
   logic             ex_valid;
   logic [REG_W-1:0] ex_rd_s;
   logic             ex_mem_rd;
   logic             ex_redirect;
   logic             imem_resp;
   logic             dmem_req;
   logic             dmem_resp;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             id_ex_bubble;
   logic             if_id_flush;
   logic             drop_imem_resp;

   modport master (
      output id_valid, id_rs1_s, id_rs2_s,
      output ex_valid, ex_rd_s, ex_mem_rd,
      output ex_redirect, imem_resp,
      output dmem_req, dmem_resp,
      input  pc_en, if_id_en, id_ex_en,
      input  ex_mem_en, mem_wb_en,
      input  id_ex_bubble, if_id_flush,
      input  drop_imem_resp
   );

   modport slave (
      input  id_valid, id_rs1_s, id_rs2_s,
      input  ex_valid, ex_rd_s, ex_mem_rd,
      input  ex_redirect, imem_resp,
      input  dmem_req, dmem_resp,
      output pc_en, if_id_en, id_ex_en,
      output ex_mem_en, mem_wb_en,
      output id_ex_bubble, if_id_flush,
      output drop_imem_resp
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose rd feeds the ID instruction.
// x0 never creates a dependency.
module hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1_s,
   input  logic [REG_W-1:0] id_rs2_s,
   input  logic             ex_valid,
   input  logic [REG_W-1:0] ex_rd_s,
   input  logic             ex_mem_rd,
   output logic             load_use
);

   logic rd_nz;
   logic hit;

   assign rd_nz = |ex_rd_s;
   assign hit   = (ex_rd_s == id_rs1_s) |
                  (ex_rd_s == id_rs2_s);

   assign load_use = ex_valid & ex_mem_rd &
                     rd_nz & id_valid & hit;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Drives stage enables, bubbles, flushes and stale-fetch drops.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_hazard_ctrl_if.slave bus,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   ctrl_state_t state;
   ctrl_state_t nxt;
   ctrl_out_t   o;
   logic        load_use;
   logic        dstall;
   logic        flush_inc;

   hazard_detect u_hd (
      .id_valid  (bus.id_valid),
      .id_rs1_s  (bus.id_rs1_s),
      .id_rs2_s  (bus.id_rs2_s),
      .ex_valid  (bus.ex_valid),
      .ex_rd_s   (bus.ex_rd_s),
      .ex_mem_rd (bus.ex_mem_rd),
      .load_use  (load_use)
   );

   assign dstall = bus.dmem_req & ~bus.dmem_resp;

   always_comb begin
      o         = OUT_FREEZE;
      nxt       = state;
      flush_inc = 1'b0;
      unique case (state)
         CTRL_RUN, CTRL_DMEM_WAIT: begin
            if (dstall) begin
               o   = OUT_FREEZE;
               nxt = CTRL_DMEM_WAIT;
            end else if (bus.ex_redirect) begin
               o         = OUT_REDIR;
               o.drop    = bus.imem_resp;
               flush_inc = 1'b1;
               nxt       = bus.imem_resp ? CTRL_RUN
                                         : CTRL_DROP;
            end else if (load_use || !bus.imem_resp) begin
               o   = OUT_HOLD;
               nxt = CTRL_RUN;
            end else begin
               o   = OUT_ALL;
               nxt = CTRL_RUN;
            end
         end
         CTRL_DROP: begin
            o        = OUT_HOLD;
            o.id_ex  = ~dstall;
            o.ex_mem = ~dstall;
            o.mem_wb = ~dstall;
            // wrong-path fetch lands: discard it, fetch target
            if (bus.imem_resp) begin
               o.pc   = 1'b1;
               o.drop = 1'b1;
               nxt    = CTRL_RUN;
            end
         end
         default: nxt = CTRL_RUN;
      endcase
   end

   assign bus.pc_en          = rst_n & o.pc;
   assign bus.if_id_en       = rst_n & o.if_id;
   assign bus.id_ex_en       = rst_n & o.id_ex;
   assign bus.ex_mem_en      = rst_n & o.ex_mem;
   assign bus.mem_wb_en      = rst_n & o.mem_wb;
   assign bus.id_ex_bubble   = rst_n & o.bubble;
   assign bus.if_id_flush    = rst_n & o.flush;
   assign bus.drop_imem_resp = rst_n & o.drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CTRL_RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= nxt;
         if (!o.pc && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised + directed bench for pipeline_hazard_ctrl.
// Reference model tracks only "fetch to wrong path outstanding".
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl #(.CNT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   bit          m_drop = 1'b0;
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ctrl_word();
      return {bus.pc_en, bus.if_id_en, bus.id_ex_en,
              bus.ex_mem_en, bus.mem_wb_en,
              bus.id_ex_bubble, bus.if_id_flush,
              bus.drop_imem_resp};
   endfunction

   task automatic set_in(input bit idv,
                         input int rs1, input int rs2,
                         input bit exv, input int rd,
                         input bit ld, input bit redir,
                         input bit imem, input bit dreq,
                         input bit dresp);
      bus.id_valid    = idv;
      bus.id_rs1_s    = 5'(rs1);
      bus.id_rs2_s    = 5'(rs2);
      bus.ex_valid    = exv;
      bus.ex_rd_s     = 5'(rd);
      bus.ex_mem_rd   = ld;
      bus.ex_redirect = redir;
      bus.imem_resp   = imem;
      bus.dmem_req    = dreq;
      bus.dmem_resp   = dresp;
   endtask

   // Called just after a falling edge with inputs applied.
   task automatic tick(input string tag);
      bit lu, ds, pc, fe, be, bub, fl, dr;
      bit nd;
      #1;
      lu = bus.ex_valid && bus.ex_mem_rd &&
           bus.ex_rd_s != 0 && bus.id_valid &&
           (bus.ex_rd_s == bus.id_rs1_s ||
            bus.ex_rd_s == bus.id_rs2_s);
      ds = bus.dmem_req && !bus.dmem_resp;
      assert (!(m_drop && bus.ex_redirect));
      pc = 0; fe = 0; be = 0;
      bub = 0; fl = 0; dr = 0;
      nd = m_drop;
      if (m_drop) begin
         be  = !ds;
         bub = 1;
         pc  = bus.imem_resp;
         dr  = bus.imem_resp;
         nd  = !bus.imem_resp;
      end else if (ds) begin
         be = 0;
      end else if (bus.ex_redirect) begin
         pc = 1; fe = 1; be = 1;
         bub = 1; fl = 1;
         dr = bus.imem_resp;
         nd = !bus.imem_resp;
      end else if (lu || !bus.imem_resp) begin
         be = 1; bub = 1;
      end else begin
         pc = 1; fe = 1; be = 1;
      end
      chk({tag, ".ctrl"}, 32'(ctrl_word()),
          32'({pc, fe, be, be, be, bub, fl, dr}));
      chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
      chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
      @(posedge clk);
      m_drop = nd;
      if (!pc) m_stall++;
      if (fl) m_flush++;
      @(negedge clk);
   endtask

   task automatic rand_in();
      bit redir;
      redir = !m_drop && ($urandom_range(0, 9) < 2);
      set_in($urandom_range(0, 3) != 0,
             $urandom_range(0, 3),
             $urandom_range(0, 3),
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3),
             $urandom_range(0, 1) == 1,
             redir,
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 3,
             $urandom_range(0, 1) == 1);
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("rst.ctrl", 32'(ctrl_word()), 32'd0);
      chk("rst.stall_cnt", stall_cnt, 32'd0);
      chk("rst.flush_cnt", flush_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // lw x5 / add x6,x5,x1: one bubble
      set_in(1, 5, 1, 1, 5, 1, 0, 1, 0, 0);
      tick("lu");
      set_in(1, 6, 2, 1, 6, 0, 0, 1, 0, 0);
      tick("lu_after");
      // lw x0 with x0 reader, then lui
      set_in(1, 0, 3, 1, 0, 1, 0, 1, 0, 0);
      tick("lw_x0");
      set_in(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
      tick("lui");
      // D-mem miss for 3 cycles
      for (int i = 0; i < 3; i++) begin
         set_in(1, 2, 3, 1, 4, 0, 0, 1, 1, 0);
         tick("dwait");
      end
      set_in(1, 2, 3, 1, 4, 0, 0, 1, 1, 1);
      tick("dresp");
      chk("dwait.stall_total", stall_cnt, 32'd4);
      // redirect with fetch outstanding
      set_in(1, 1, 2, 1, 3, 0, 1, 0, 0, 0);
      tick("redir");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick("drop_wait");
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick("drop_resp");
      chk("redir.flush_total", flush_cnt, 32'd1);
      // redirect + load_use + dstall together
      set_in(1, 7, 0, 1, 7, 1, 1, 1, 1, 0);
      tick("triple");
      set_in(1, 7, 0, 1, 7, 1, 1, 1, 1, 1);
      tick("triple_resp");
      chk("triple.flush_total", flush_cnt, 32'd2);

      for (int i = 0; i < 3000; i++) begin
         rand_in();
         tick("rnd");
      end

      // reset while in DROP
      set_in(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      if (!m_drop) tick("pre_drop");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick("in_drop");
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid.ctrl", 32'(ctrl_word()), 32'd0);
      m_drop = 0;
      m_stall = 0;
      m_flush = 0;
      @(negedge clk);
      chk("rst_mid.stall_cnt", stall_cnt, 32'd0);
      chk("rst_mid.flush_cnt", flush_cnt, 32'd0);
      rst_n = 1'b1;
      set_in(1, 1, 2, 1, 3, 0, 0, 1, 0, 0);
      tick("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
